// File: rtl/acappella_pkg.sv
// Shared definitions for the a-cappella audio engines: SDRAM geometry,
// requester indices and the arbiter state encoding.
package acappella_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DONE
  } arb_state_t;

  localparam int SDRAM_ADDR_W = 23;
  localparam int SDRAM_DATA_W = 32;

  localparam int REQ_REC   = 0;
  localparam int REQ_PLAY  = 1;
  localparam int REQ_PITCH = 2;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Engine-side handshake and Avalon-MM side of the SDRAM arbiter.
// master = the arbiter itself, slave = engines plus SDRAM controller.
interface sdram_arbiter_if
  import acappella_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = SDRAM_ADDR_W,
  parameter int DATA_W  = SDRAM_DATA_W
);
  logic [NUM_REQ-1:0]             req_read;
  logic [NUM_REQ-1:0]             req_write;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_writedata;
  logic [DATA_W-1:0]              req_readdata;
  logic [NUM_REQ-1:0]             req_finished;

  logic [ADDR_W-1:0] sdram_address;
  logic              sdram_read;
  logic              sdram_write;
  logic [DATA_W-1:0] sdram_writedata;
  logic [DATA_W-1:0] sdram_readdata;
  logic              sdram_readdatavalid;
  logic              sdram_waitrequest;

  modport master (
    input  req_read, req_write, req_addr, req_writedata,
    output req_readdata, req_finished,
    output sdram_address, sdram_read, sdram_write, sdram_writedata,
    input  sdram_readdata, sdram_readdatavalid, sdram_waitrequest
  );

  modport slave (
    output req_read, req_write, req_addr, req_writedata,
    input  req_readdata, req_finished,
    input  sdram_address, sdram_read, sdram_write, sdram_writedata,
    output sdram_readdata, sdram_readdatavalid, sdram_waitrequest
  );
endinterface

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin select: first active index at or after rr_ptr,
// wrapping modulo NUM_REQ. Assumes NUM_REQ >= 2 and rr_ptr < NUM_REQ.
module rr_picker #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         active,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  output logic [$clog2(NUM_REQ)-1:0] grant,
  output logic                       any_active
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][IDX_W-1:0] cand_idx;
  logic [NUM_REQ-1:0]            cand_hit;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = (rr_ptr >= IDX_W'(NUM_REQ - gi)) ? rr_ptr - IDX_W'(NUM_REQ - gi)
                                                            : rr_ptr + IDX_W'(gi);
    assign cand_hit[gi] = active[cand_idx[gi]];
  end

  // Scan from the farthest offset down so the closest one to rr_ptr wins.
  always_comb begin
    grant      = '0;
    any_active = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        grant      = cand_idx[k];
        any_active = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter turning engine read/write/finished handshakes into
// single-outstanding Avalon-MM transactions toward the SDRAM controller.
module sdram_arbiter
  import acappella_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = SDRAM_ADDR_W,
  parameter int DATA_W  = SDRAM_DATA_W
) (
  input logic            i_clk,
  input logic            i_rst,
  sdram_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               op_read_q, op_read_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [DATA_W-1:0]  writedata_q, writedata_d;
  logic [DATA_W-1:0]  readdata_q, readdata_d;
  logic               sdram_read_q, sdram_read_d;
  logic               sdram_write_q, sdram_write_d;
  logic [NUM_REQ-1:0] finished_q, finished_d;

  logic [NUM_REQ-1:0] active;
  logic [IDX_W-1:0]   pick_idx;
  logic               any_active;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_active
    assign active[gi] = bus.req_read[gi] | bus.req_write[gi];
  end

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .active     (active),
    .rr_ptr     (rr_ptr_q),
    .grant      (pick_idx),
    .any_active (any_active)
  );

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    op_read_d     = op_read_q;
    address_d     = address_q;
    writedata_d   = writedata_q;
    readdata_d    = readdata_q;
    sdram_read_d  = sdram_read_q;
    sdram_write_d = sdram_write_q;
    finished_d    = '0;
    case (state_q)
      IDLE: begin
        if (any_active) begin
          grant_d       = pick_idx;
          op_read_d     = bus.req_read[pick_idx];
          address_d     = bus.req_addr[pick_idx];
          writedata_d   = bus.req_writedata[pick_idx];
          sdram_read_d  = bus.req_read[pick_idx];
          sdram_write_d = ~bus.req_read[pick_idx];
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (!bus.sdram_waitrequest) begin
          sdram_read_d  = 1'b0;
          sdram_write_d = 1'b0;
          if (op_read_q) begin
            state_d = WAIT_RD;
          end else begin
            finished_d[grant_q] = 1'b1;
            state_d             = DONE;
          end
        end
      end
      WAIT_RD: begin
        if (bus.sdram_readdatavalid) begin
          readdata_d          = bus.sdram_readdata;
          finished_d[grant_q] = 1'b1;
          state_d             = DONE;
        end
      end
      DONE: begin
        rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      op_read_q     <= 1'b0;
      address_q     <= '0;
      writedata_q   <= '0;
      readdata_q    <= '0;
      sdram_read_q  <= 1'b0;
      sdram_write_q <= 1'b0;
      finished_q    <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      op_read_q     <= op_read_d;
      address_q     <= address_d;
      writedata_q   <= writedata_d;
      readdata_q    <= readdata_d;
      sdram_read_q  <= sdram_read_d;
      sdram_write_q <= sdram_write_d;
      finished_q    <= finished_d;
    end
  end

  assign bus.sdram_address   = address_q;
  assign bus.sdram_writedata = writedata_q;
  assign bus.sdram_read      = sdram_read_q;
  assign bus.sdram_write     = sdram_write_q;
  assign bus.req_readdata    = readdata_q;
  assign bus.req_finished    = finished_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: the driver queues expected Avalon
// accepts and finished pulses, a negedge monitor pops and compares them.
module tb_sdram_arbiter;
  import acappella_pkg::*;

  localparam int NR = 3;
  localparam int AW = SDRAM_ADDR_W;
  localparam int DW = SDRAM_DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    bit            rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } av_exp_t;

  typedef struct {
    logic [NR-1:0] vec;
    bit            rd;
    logic [DW-1:0] data;
    int            cyc;
  } fin_exp_t;

  av_exp_t  av_q[$];
  fin_exp_t fin_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented Avalon access and finished pulse.
  always @(negedge clk) begin
    if (bus.sdram_read || bus.sdram_write) begin
      chk("rd_wr_exclusive", 64'(bus.sdram_read & bus.sdram_write), 64'd0);
      if (av_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL av_unexpected: got rd=%0b wr=%0b addr=0x%0h required no access (cycle %0d)",
                 bus.sdram_read, bus.sdram_write, bus.sdram_address, cyc);
      end else begin
        chk("av_op_read", 64'(bus.sdram_read), 64'(av_q[0].rd));
        chk("av_address", 64'(bus.sdram_address), 64'(av_q[0].addr));
        if (!av_q[0].rd) chk("av_writedata", 64'(bus.sdram_writedata), 64'(av_q[0].data));
        if (!bus.sdram_waitrequest) begin
          chk("av_accept_cycle", 64'(cyc), 64'(av_q[0].cyc));
          $display("AV %s addr=0x%06h data=0x%08h cycle=%0d",
                   bus.sdram_read ? "READ " : "WRITE", bus.sdram_address, bus.sdram_writedata, cyc);
          void'(av_q.pop_front());
        end
      end
    end
    if (bus.req_finished != '0) begin
      if (fin_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL finished_unexpected: got 0b%03b required none (cycle %0d)", bus.req_finished, cyc);
      end else begin
        chk("finished_vec", 64'(bus.req_finished), 64'(fin_q[0].vec));
        chk("finished_cycle", 64'(cyc), 64'(fin_q[0].cyc));
        if (fin_q[0].rd) chk("readdata", 64'(bus.req_readdata), 64'(fin_q[0].data));
        $display("FIN vec=0b%03b readdata=0x%08h cycle=%0d", bus.req_finished, bus.req_readdata, cyc);
        void'(fin_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((av_q.size() != 0 || fin_q.size() != 0) && n < 60) begin
      step();
      n++;
    end
    chk({name, "_av_pending"}, 64'(av_q.size()), 64'd0);
    chk({name, "_fin_pending"}, 64'(fin_q.size()), 64'd0);
    step();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_sdram_read"}, 64'(bus.sdram_read), 64'd0);
    chk({name, "_sdram_write"}, 64'(bus.sdram_write), 64'd0);
    chk({name, "_sdram_address"}, 64'(bus.sdram_address), 64'd0);
    chk({name, "_sdram_writedata"}, 64'(bus.sdram_writedata), 64'd0);
    chk({name, "_req_readdata"}, 64'(bus.req_readdata), 64'd0);
    chk({name, "_req_finished"}, 64'(bus.req_finished), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    bus.req_read            = '0;
    bus.req_write           = '0;
    bus.req_addr            = '0;
    bus.req_writedata       = '0;
    bus.sdram_readdata      = '0;
    bus.sdram_readdatavalid = 1'b0;
    bus.sdram_waitrequest   = 1'b0;
    repeat (3) step();
    chk_outputs_zero("reset");
    rst = 1'b0;
    step();

    // Stale readdatavalid in IDLE must not touch readdata or finish anything.
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 32'hBAD0BAD0;
    step();
    bus.sdram_readdatavalid = 1'b0;
    step();
    chk("stale_rdv_readdata", 64'(bus.req_readdata), 64'd0);

    // Single write from the pitch core, no stall.
    c = cyc;
    bus.req_write[REQ_PITCH]     = 1'b1;
    bus.req_addr[REQ_PITCH]      = 23'h000010;
    bus.req_writedata[REQ_PITCH] = 32'hDEADBEEF;
    av_q.push_back('{rd: 1'b0, addr: 23'h000010, data: 32'hDEADBEEF, cyc: c + 1});
    fin_q.push_back('{vec: 3'b100, rd: 1'b0, data: '0, cyc: c + 2});
    wait_until(c + 2);
    bus.req_write[REQ_PITCH] = 1'b0;
    drain("write");

    // Read from the player, readdatavalid 4 cycles after acceptance.
    c = cyc;
    bus.req_read[REQ_PLAY] = 1'b1;
    bus.req_addr[REQ_PLAY] = 23'h7FFFFF;
    av_q.push_back('{rd: 1'b1, addr: 23'h7FFFFF, data: '0, cyc: c + 1});
    fin_q.push_back('{vec: 3'b010, rd: 1'b1, data: 32'h12345678, cyc: c + 6});
    wait_until(c + 5);
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 32'h12345678;
    step();
    bus.sdram_readdatavalid  = 1'b0;
    bus.req_read[REQ_PLAY]   = 1'b0;
    drain("read");

    // Write stalled for 5 cycles by waitrequest.
    c = cyc;
    bus.sdram_waitrequest      = 1'b1;
    bus.req_write[REQ_REC]     = 1'b1;
    bus.req_addr[REQ_REC]      = 23'h0ABCDE;
    bus.req_writedata[REQ_REC] = 32'hCAFEF00D;
    av_q.push_back('{rd: 1'b0, addr: 23'h0ABCDE, data: 32'hCAFEF00D, cyc: c + 6});
    fin_q.push_back('{vec: 3'b001, rd: 1'b0, data: '0, cyc: c + 7});
    wait_until(c + 6);
    bus.sdram_waitrequest = 1'b0;
    wait_until(c + 7);
    bus.req_write[REQ_REC] = 1'b0;
    drain("stall");

    // Read and write both set on the recorder: read wins.
    c = cyc;
    bus.req_read[REQ_REC]      = 1'b1;
    bus.req_write[REQ_REC]     = 1'b1;
    bus.req_addr[REQ_REC]      = 23'h000123;
    bus.req_writedata[REQ_REC] = 32'h0000FFFF;
    av_q.push_back('{rd: 1'b1, addr: 23'h000123, data: '0, cyc: c + 1});
    fin_q.push_back('{vec: 3'b001, rd: 1'b1, data: 32'hA5A50001, cyc: c + 3});
    wait_until(c + 2);
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 32'hA5A50001;
    step();
    bus.sdram_readdatavalid = 1'b0;
    bus.req_read[REQ_REC]   = 1'b0;
    bus.req_write[REQ_REC]  = 1'b0;
    drain("rdwr");

    // Reset while waiting for read data: outputs clear at once, no finish.
    c = cyc;
    bus.req_read[REQ_PLAY] = 1'b1;
    bus.req_addr[REQ_PLAY] = 23'h055555;
    av_q.push_back('{rd: 1'b1, addr: 23'h055555, data: '0, cyc: c + 1});
    wait_until(c + 3);
    rst = 1'b1;
    bus.req_read[REQ_PLAY] = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    step();
    step();
    rst = 1'b0;
    step();
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 32'hFFFF0000;
    step();
    bus.sdram_readdatavalid = 1'b0;
    repeat (4) step();
    chk("late_rdv_readdata", 64'(bus.req_readdata), 64'd0);
    drain("midreset");

    // Fairness: all three write continuously from rr_ptr = 0.
    c = cyc;
    for (int i = 0; i < NR; i++) begin
      bus.req_write[i]     = 1'b1;
      bus.req_addr[i]      = AW'(32'h100 + i);
      bus.req_writedata[i] = DW'(32'h11110000 + i);
    end
    for (int j = 0; j < 6; j++) begin
      av_q.push_back('{rd: 1'b0, addr: AW'(32'h100 + (j % 3)), data: DW'(32'h11110000 + (j % 3)),
                       cyc: c + 1 + 3 * j});
      fin_q.push_back('{vec: NR'(1 << (j % 3)), rd: 1'b0, data: '0, cyc: c + 2 + 3 * j});
    end
    wait_until(c + 17);
    bus.req_write = '0;
    drain("fair");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM port among the audio engines: recorder, player and pitch core. Each engine uses the read/write/finished handshake that PitchCore already drives. The arbiter serialises their word accesses with round-robin fairness and converts each one into an Avalon-MM master transaction toward the SDRAM controller. It sits between the engines and the SDRAM controller IP, and only one transaction is outstanding at any time.

## Interface
Parameters:
- NUM_REQ, 3, number of requesters (0 = recorder, 1 = player, 2 = pitch core)
- ADDR_W, 23, word address width
- DATA_W, 32, data width

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  system clock
- i_rst  in  1  asynchronous active-high reset
- req_read  in  NUM_REQ  per-requester read request, held until its finished pulse
- req_write  in  NUM_REQ  per-requester write request, held until its finished pulse
- req_addr  in  NUM_REQ x ADDR_W  per-requester address
- req_writedata  in  NUM_REQ x DATA_W  per-requester write data
- req_readdata  out  DATA_W  last read word, shared by all requesters
- req_finished  out  NUM_REQ  one-cycle completion pulse to the granted requester
- sdram_address  out  ADDR_W  Avalon address
- sdram_read  out  1  Avalon read
- sdram_write  out  1  Avalon write
- sdram_writedata  out  DATA_W  Avalon write data
- sdram_readdata  in  DATA_W  Avalon read data
- sdram_readdatavalid  in  1  Avalon read data valid
- sdram_waitrequest  in  1  Avalon stall

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, DONE.
- IDLE:
  - A requester is active if req_read[i] or req_write[i] is set.
  - The winner is the first active index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Latch grant, op (read wins if both bits are set), address and write data into registers, then go to ISSUE.
  - If no requester is active, stay in IDLE.
- ISSUE:
  - Drive sdram_read or sdram_write with the latched address and data; the outputs come from registers only.
  - Hold while sdram_waitrequest = 1.
  - When waitrequest = 0, a write goes to DONE and a read goes to WAIT_RD.
- WAIT_RD: on sdram_readdatavalid = 1, capture sdram_readdata into req_readdata and go to DONE.
- DONE:
  - req_finished[grant] = 1 for exactly this cycle.
  - rr_ptr <= (grant + 1) mod NUM_REQ.
  - Go to IDLE.
- req_readdata holds its value until the next read capture. It is not cleared by writes.
- A requester that drops its request mid-transaction does not abort it. The access completes and the finished pulse is still issued.
- Requests that change while granted are ignored; the latched copy is used.
- readdatavalid seen in any state other than WAIT_RD is ignored, e.g. a stale read after reset.
- Requesters must drop the request at the edge where they sample finished = 1. A request still high in the following IDLE cycle is treated as a new access.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, grant = 0.
  - sdram_read = 0, sdram_write = 0.
  - sdram_address, sdram_writedata, req_readdata = 0.
  - req_finished = 0.
- Write, no stall: request seen in IDLE at cycle 0, sdram_write = 1 at cycle 1, req_finished at cycle 2. Each stall cycle adds 1.
- Read: sdram_read = 1 at cycle 1.
  - If readdatavalid arrives at cycle k (k ≥ 2), req_readdata is updated and req_finished pulses at cycle k+1.
  - req_readdata is valid in the finished cycle.
- Back-to-back throughput: a single requester gets at most one write per 3 cycles.
- Only one of sdram_read / sdram_write is ever high, and only in ISSUE.
- Reset mid-transaction takes effect immediately (asynchronous): outputs drop to their reset values, no finished pulse is issued, and the pending access is lost.

## Structure
- The shared package acappella_pkg holds:
  - typedef arb_state_t (IDLE, ISSUE, WAIT_RD, DONE)
  - SDRAM_ADDR_W = 23, SDRAM_DATA_W = 32
  - requester index constants REQ_REC = 0, REQ_PLAY = 1, REQ_PITCH = 2
- One sub-module, rr_picker: combinational round-robin priority select.
  - Inputs: active vector and rr_ptr.
  - Outputs: grant index and any_active.
  - Parameterised by NUM_REQ.

## Test plan
- Single write: req_write[2] = 1, addr 0x000010, data 0xDEADBEEF, waitrequest = 0 → sdram_write at cycle 1 with those values; req_finished = 3'b100 at cycle 2 only.
- Read with latency: req_read[1] = 1, addr 0x7FFFFF; readdatavalid with 0x12345678 arrives 4 cycles after acceptance → req_readdata = 0x12345678 and req_finished = 3'b010 in the following cycle.
- Stall: waitrequest held high for 5 cycles during a write → address and data stable throughout; finished pulses 1 cycle after waitrequest falls.
- Fairness: all three requesters hold requests continuously, starting from rr_ptr = 0 → grant order 0, 1, 2, 0, 1, 2; no requester gets two grants in a row.
- Read and write on the same requester: req_read[0] = req_write[0] = 1 → only sdram_read is issued.
- Reset mid-read: assert i_rst in WAIT_RD → all outputs go to 0 immediately; a late readdatavalid after reset is ignored and no finished pulse occurs.
